// File: rtl/led_shade_sequencer_pkg.sv
// Shared types and constants for the LED shade sequencer.
package led_shade_sequencer_pkg;

  localparam int NCH   = 8;
  localparam int DIV_W = 4;

  localparam logic [3:0] A_CTRL   = 4'd8;
  localparam logic [3:0] A_LVL    = 4'd9;
  localparam logic [3:0] A_STATUS = 4'd10;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_FADE   = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPD    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Per-frame parameters frozen at the frame pulse so mid-frame host writes
  // only land on the next frame.
  typedef struct packed {
    mode_e      mode;
    logic [7:0] lvl;
    logic       step_en;
  } snap_t;

endpackage

// File: rtl/led_shade_sequencer_step.sv
// Shared per-channel level step: one instance, time-multiplexed over channels.
module led_level_step
  import led_shade_sequencer_pkg::*;
(
  input  mode_e      mode,
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  input  logic [7:0] lvl,
  input  logic [2:0] ch,
  input  logic [2:0] pos,
  input  logic       step_en,
  output logic [7:0] nxt
);

  // Next level for the channel currently selected by the sequencer.
  always_comb begin
    nxt = tgt;
    case (mode)
      MODE_FADE: begin
        nxt = cur;
        if (step_en) begin
          if (cur < tgt)      nxt = cur + 8'd1;
          else if (cur > tgt) nxt = cur - 8'd1;
        end
      end
      MODE_CHASE: begin
        // Head at pos, a quarter-bright tail one channel behind (wraps 0 -> 7).
        if (ch == pos)               nxt = lvl;
        else if (ch == pos - 3'd1)   nxt = {2'b00, lvl[7:2]};
        else                         nxt = 8'd0;
      end
      default: nxt = tgt;
    endcase
  end

endmodule

// File: rtl/led_shade_sequencer.sv
// Frame-synchronous brightness sequencer: serial per-channel update, atomic commit.
module led_shade_sequencer
  import led_shade_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       fclk,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [7:0] data_a,
  output logic [7:0] data_b,
  output logic [7:0] data_c,
  output logic [7:0] data_d,
  output logic [7:0] data_e,
  output logic [7:0] data_f,
  output logic [7:0] data_g,
  output logic [7:0] data_h
);

  logic [NCH-1:0][7:0] tgt, cur, data;
  mode_e               mode;
  logic [DIV_W-1:0]    div, fcnt;
  logic [7:0]          lvl;
  logic [2:0]          pos, ch;
  logic                overrun;
  snap_t               snap;
  state_e              state, state_nx;
  logic [7:0]          step_out;

  logic fire, ctrl_wr, step_now;
  assign fire     = (state == ST_IDLE) && fclk;
  assign ctrl_wr  = wr_en && (wr_addr == A_CTRL);
  assign step_now = (fcnt == div);

  led_level_step u_step (
    .mode    (snap.mode),
    .cur     (cur[ch]),
    .tgt     (tgt[ch]),
    .lvl     (snap.lvl),
    .ch      (ch),
    .pos     (pos),
    .step_en (snap.step_en),
    .nxt     (step_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // FSM next state: eight update cycles then one commit cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (fclk) state_nx = ST_UPD;
      ST_UPD:    if (ch == 3'd7) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Host-visible register file.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tgt  <= '0;
      mode <= MODE_DIRECT;
      div  <= '0;
      lvl  <= '0;
    end else if (wr_en) begin
      if (!wr_addr[3]) tgt[wr_addr[2:0]] <= wr_data;
      else if (wr_addr == A_CTRL) begin
        div  <= wr_data[7:4];
        mode <= mode_e'(wr_data[1:0]);
      end else if (wr_addr == A_LVL) lvl <= wr_data;
    end
  end

  // Frame prescaler and chase head; a CTRL write restarts the prescale count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fcnt <= '0;
      pos  <= '0;
    end else begin
      if (ctrl_wr)   fcnt <= '0;
      else if (fire) fcnt <= step_now ? '0 : fcnt + DIV_W'(1);
      if (ctrl_wr && (mode_e'(wr_data[1:0]) != mode))
        pos <= '0;
      else if (state == ST_COMMIT && snap.mode == MODE_CHASE && snap.step_en)
        pos <= pos + 3'd1;
    end
  end

  // Frame snapshot, channel index and working levels.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      snap <= '0;
      ch   <= '0;
      cur  <= '0;
    end else if (fire) begin
      snap <= '{mode: mode, lvl: lvl, step_en: step_now};
      ch   <= '0;
    end else if (state == ST_UPD) begin
      cur[ch] <= step_out;
      ch      <= ch + 3'd1;
    end
  end

  // Atomic commit of all channels to the PWM.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                 data <= '0;
    else if (state == ST_COMMIT) data <= cur;
  end

  // Overrun flag; a frame pulse dropped while busy beats a same-cycle clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) overrun <= 1'b0;
    else if (fclk && state != ST_IDLE) overrun <= 1'b1;
    else if (wr_en && wr_addr == A_STATUS && wr_data[1]) overrun <= 1'b0;
  end

  // Registered read mux.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rd_data <= '0;
    else if (!rd_addr[3]) rd_data <= tgt[rd_addr[2:0]];
    else begin
      case (rd_addr)
        A_CTRL:   rd_data <= {div, 2'b00, mode};
        A_LVL:    rd_data <= lvl;
        A_STATUS: rd_data <= {6'b0, overrun, busy};
        default:  rd_data <= 8'd0;
      endcase
    end
  end

  assign data_a = data[0];
  assign data_b = data[1];
  assign data_c = data[2];
  assign data_d = data[3];
  assign data_e = data[4];
  assign data_f = data[5];
  assign data_g = data[6];
  assign data_h = data[7];

endmodule

// File: tb/tb_led_shade_sequencer.sv
// Directed bench with a frame-level reference model and expected-frame queue.
module tb_led_shade_sequencer;

  logic       clk = 1'b0;
  logic       nreset, fclk, wr_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy;
  logic [7:0] data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h;
  logic [63:0] dout;

  assign dout = {data_h, data_g, data_f, data_e, data_d, data_c, data_b, data_a};

  led_shade_sequencer dut (
    .clk(clk), .nreset(nreset), .fclk(fclk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .data_e(data_e), .data_f(data_f), .data_g(data_g), .data_h(data_h)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_tgt [8];
  logic [7:0] m_cur [8];
  logic [1:0] m_mode;
  logic [3:0] m_div, m_fcnt;
  logic [7:0] m_lvl;
  logic [2:0] m_pos;
  logic [63:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_tgt[i] = 8'd0; m_cur[i] = 8'd0; end
    m_mode = 2'd0; m_div = 4'd0; m_fcnt = 4'd0; m_lvl = 8'd0; m_pos = 3'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 4'd8) m_tgt[a[2:0]] = d;
    else if (a == 4'd8) begin
      if (d[1:0] != m_mode) m_pos = 3'd0;
      m_mode = d[1:0]; m_div = d[7:4]; m_fcnt = 4'd0;
    end else if (a == 4'd9) m_lvl = d;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, {56'd0, rd_data}, {56'd0, exp});
  endtask

  // One frame: model the expected commit, pulse fclk, follow busy to completion.
  // extra_at > 0 pulses fclk again mid-update; rst_at > 0 asserts reset mid-update.
  task automatic frame(input string tag, input int extra_at, input int rst_at);
    logic        se;
    logic [63:0] exp, pre;
    int          n, tail;
    bit          aborted;
    se = (m_fcnt == m_div);
    m_fcnt = se ? 4'd0 : m_fcnt + 4'd1;
    tail = (int'(m_pos) + 7) % 8;
    for (int c = 0; c < 8; c++) begin
      case (m_mode)
        2'd1: if (se) begin
          if (m_cur[c] < m_tgt[c])      m_cur[c] = m_cur[c] + 8'd1;
          else if (m_cur[c] > m_tgt[c]) m_cur[c] = m_cur[c] - 8'd1;
        end
        2'd2: m_cur[c] = (c == int'(m_pos)) ? m_lvl : (c == tail) ? (m_lvl >> 2) : 8'd0;
        default: m_cur[c] = m_tgt[c];
      endcase
      exp[c*8 +: 8] = m_cur[c];
    end
    if (m_mode == 2'd2 && se) m_pos = m_pos + 3'd1;
    sb.push_back(exp);
    pre = dout;
    @(negedge clk); fclk = 1'b1;
    @(negedge clk); fclk = 1'b0;
    n = 0; aborted = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      if (n == rst_at) begin
        nreset = 1'b0;
        #1;
        check({tag, "_rst_data"}, dout, 64'd0);
        check({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_rst_rd"}, {56'd0, rd_data}, 64'd0);
        aborted = 1;
        break;
      end
      if (n == 9) check({tag, "_hold"}, dout, pre);
      fclk = (n == extra_at);
      @(negedge clk);
    end
    fclk = 1'b0;
    if (aborted) begin
      void'(sb.pop_front());
      model_reset();
      @(negedge clk); nreset = 1'b1;
      return;
    end
    check({tag, "_busy_len"}, 64'(n), 64'd9);
    if (sb.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
    else check(tag, dout, sb.pop_front());
  endtask

  initial begin
    nreset = 1'b0; fclk = 1'b0; wr_en = 1'b0;
    wr_addr = 4'd0; wr_data = 8'd0; rd_addr = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_data", dout, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_rd", {56'd0, rd_data}, 64'd0);
    nreset = 1'b1;

    // 1: DIRECT
    wr(4'd0, 8'h80);
    rd("rd_tgt0", 4'd0, 8'h80);
    frame("direct", 0, 0);
    check("direct_a", {56'd0, data_a}, 64'h80);

    // 2: FADE div=0, ramp up then back down
    wr(4'd8, 8'h01);
    wr(4'd1, 8'd3);
    for (int i = 0; i < 5; i++) frame("fade_up", 0, 0);
    check("fade_up_b", {56'd0, data_b}, 64'd3);
    wr(4'd1, 8'd1);
    for (int i = 0; i < 3; i++) frame("fade_dn", 0, 0);
    check("fade_dn_b", {56'd0, data_b}, 64'd1);

    // 3: FADE div=2, then CTRL rewrite restarts the prescale count
    wr(4'd2, 8'd5);
    wr(4'd8, 8'h21);
    rd("rd_ctrl", 4'd8, 8'h21);
    for (int i = 0; i < 4; i++) frame("fade_div", 0, 0);
    wr(4'd8, 8'h21);
    for (int i = 0; i < 3; i++) frame("fade_rst", 0, 0);
    check("fade_div_c", {56'd0, data_c}, 64'd2);

    // 4: CHASE full walk and wrap, then mode change re-homes the head
    wr(4'd9, 8'hFF);
    wr(4'd8, 8'h02);
    rd("rd_lvl", 4'd9, 8'hFF);
    frame("chase1", 0, 0);
    check("chase1_ah", {48'd0, data_h, data_a}, {48'd0, 8'h3F, 8'hFF});
    for (int i = 0; i < 8; i++) frame("chase", 0, 0);
    check("chase9_ah", {48'd0, data_h, data_a}, {48'd0, 8'h3F, 8'hFF});
    frame("chase", 0, 0);
    frame("chase", 0, 0);
    wr(4'd8, 8'h00);
    wr(4'd8, 8'h02);
    frame("chase_home", 0, 0);
    check("chase_home_a", {56'd0, data_a}, 64'hFF);

    // 5: dropped frame pulse sets overrun; write-1 clears it
    frame("overrun", 3, 0);
    rd("status_ovr", 4'd10, 8'h02);
    wr(4'd10, 8'h02);
    rd("status_clr", 4'd10, 8'h00);
    wr(4'd12, 8'h5A);
    rd("rd_unmapped", 4'd12, 8'h00);

    // 6: reset mid FADE update, then DIRECT on the following frame
    wr(4'd8, 8'h01);
    wr(4'd3, 8'h40);
    frame("pre_rst", 0, 0);
    frame("mid_rst", 0, 5);
    wr(4'd0, 8'h11);
    frame("post_rst", 0, 0);
    check("post_rst_a", {56'd0, data_a}, 64'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
